// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. The IF stage looks up the fetch PC and gets a predicted next PC
// in the same cycle. EX reports resolved branches back to train the table. A
// saturating misprediction counter is kept for performance measurement.
//
// Address split: idx = pc[IDX_W+1:2], tag = pc[ADDR_W-1:IDX_W+2].
// The low two PC bits are ignored.
//
// Ports
//   clk_i             clock; all state updates happen on the rising edge
//   rst_i             asynchronous reset, active-high
//   lookup_pc_i       PC of the instruction being fetched
//   pred_hit_o        lookup PC matches a valid entry
//   pred_taken_o      predicted taken
//   pred_target_o     predicted next PC (stored target, or lookup_pc_i + 4)
//   update_valid_i    a resolved branch is presented this cycle
//   update_pc_i       PC of the resolved branch
//   update_taken_i    actual direction
//   update_target_i   actual taken target
//   clear_i           synchronous invalidate of all entries
//   mispredict_cnt_o  saturating misprediction count
//
// Handshake: update_valid_i is a valid-only strobe with no ready. The
// predictor always accepts it, and consumes it at the rising edge where it is
// sampled high. The only exceptions are when rst_i or clear_i is high; in
// those cases the update is dropped.
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              update_valid_i,
  input  logic [ADDR_W-1:0] update_pc_i,
  input  logic              update_taken_i,
  input  logic [ADDR_W-1:0] update_target_i,
  input  logic              clear_i,
  output logic [STAT_W-1:0] mispredict_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0]  CTR_MAX  = '1;
  localparam logic [CNT_W-1:0]  CTR_WT   = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0]  CTR_WNT  = CNT_W'(CTR_WT - CNT_W'(1));
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Table state
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0]   ctr_q    [ENTRIES];
  logic [STAT_W-1:0]  mispredict_cnt_q;

  // Lookup side (combinational from registered state)
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;

  // Update side (evaluated against pre-edge state)
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_pred_taken;
  logic             up_mispredict;
  logic [CNT_W-1:0] up_ctr;
  logic [CNT_W-1:0] up_ctr_inc;
  logic [CNT_W-1:0] up_ctr_dec;

  // The low PC bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];

  always_comb begin
    pred_hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o  = pred_hit_o && ctr_q[lk_idx][CNT_W-1];
    pred_target_o = pred_taken_o ? target_q[lk_idx]
                                 : lookup_pc_i + ADDR_W'(4);
  end

  assign up_idx = update_pc_i[IDX_W+1:2];
  assign up_tag = update_pc_i[ADDR_W-1:IDX_W+2];

  always_comb begin
    up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_ctr        = ctr_q[up_idx];
    up_pred_taken = up_hit && up_ctr[CNT_W-1];
    // A wrong direction is a mispredict. So is a correct "taken" guess that
    // would have fetched from the wrong target.
    up_mispredict = (up_pred_taken != update_taken_i) ||
                    (up_pred_taken && update_taken_i &&
                     (target_q[up_idx] != update_target_i));
    up_ctr_inc    = (up_ctr == CTR_MAX) ? up_ctr : up_ctr + CNT_W'(1);
    up_ctr_dec    = (up_ctr == '0)      ? up_ctr : up_ctr - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q          <= '0;
      mispredict_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (clear_i) begin
      // Clear wins over a same-cycle update; that update is not counted.
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else if (update_valid_i) begin
      if (up_hit) begin
        if (update_taken_i) begin
          ctr_q[up_idx]    <= up_ctr_inc;
          target_q[up_idx] <= update_target_i;
        end else begin
          ctr_q[up_idx]    <= up_ctr_dec;
        end
      end else if (update_taken_i) begin
        // Allocate, or replace an aliasing entry. Start at weakly-taken.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target_i;
        ctr_q[up_idx]    <= CTR_WT;
      end
      if (up_mispredict && (mispredict_cnt_q != STAT_MAX)) begin
        mispredict_cnt_q <= mispredict_cnt_q + STAT_W'(1);
      end
    end
  end

  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters for the pipelined MIPS core.
- Generalises the static "not taken, resolve in EX" branch path: the IF stage looks up the current PC and gets a predicted next PC in the same cycle.
- EX reports resolved branches back to train the table.
- Also keeps a saturating misprediction counter for performance measurement.

Parameters:
- ADDR_W, 32: PC / target width in bits.
- ENTRIES, 16: table entries; power of two, at least 2. IDX_W = log2(ENTRIES).
- CNT_W, 2: direction counter width, at least 1.
- STAT_W, 16: misprediction counter width.
- Derived: TAG_W = ADDR_W - IDX_W - 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- lookup_pc_i  in  ADDR_W  PC of the instruction being fetched.
- pred_hit_o  out  1  lookup PC matches a valid entry.
- pred_taken_o  out  1  predicted taken.
- pred_target_o  out  ADDR_W  predicted next PC.
- update_valid_i  in  1  a resolved branch is presented this cycle.
- update_pc_i  in  ADDR_W  PC of the resolved branch.
- update_taken_i  in  1  actual direction.
- update_target_i  in  ADDR_W  actual taken target.
- clear_i  in  1  synchronous invalidate of all entries.
- mispredict_cnt_o  out  STAT_W  saturating misprediction count.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[ADDR_W-1:IDX_W+2]
  - pc[1:0] ignored.
- Entry contents: valid (1 bit), tag (TAG_W), target (ADDR_W), ctr (CNT_W).
- Lookup is combinational from registered state; zero latency.
  - hit = valid[idx] & (tag[idx] == lookup tag).
  - pred_taken_o = hit & ctr[idx][CNT_W-1].
  - pred_target_o = stored target when pred_taken_o, else lookup_pc_i + 4 (mod 2^ADDR_W).
- Update, evaluated at the clock edge when update_valid_i = 1, against pre-edge state:
  - Entry hit:
    - Taken: ctr increments, saturating at all-ones; target is overwritten with update_target_i.
    - Not taken: ctr decrements, saturating at 0; target is kept.
  - Entry miss and taken: allocate or replace the entry. valid=1, tag and target written, ctr = WT (weakly taken) = 1 << (CNT_W-1).
  - Entry miss and not taken: no change; no allocation.
- Misprediction, computed from pre-edge state with the same rule as lookup:
  - Counted when the predicted direction != update_taken_i.
  - Also counted when both are taken but the stored target != update_target_i.
  - Counter increments by 1 and saturates at all-ones; it never wraps.
- clear_i = 1:
  - At the edge, all valid bits go to 0 and all ctr go to WNT (weakly not-taken) = (1 << (CNT_W-1)) - 1.
  - Has priority over a simultaneous update; that update is dropped and not counted.
  - mispredict_cnt_o is not cleared.
- Lookup and update to the same index in the same cycle: the lookup sees pre-edge contents; no bypass.
- CNT_W = 1: WT = 1, WNT = 0; the counter behaves as a last-outcome bit.
- Reset (asynchronous, takes effect immediately, including mid-stream):
  - All valid = 0, all ctr = WNT, mispredict_cnt_o = 0.
  - Outputs immediately read pred_hit_o = 0, pred_taken_o = 0, pred_target_o = lookup_pc_i + 4.
  - Updates presented while rst_i is high are ignored.
- Targets and tags reset to 0; their values are don't-care while the entry is invalid.

Test Plan:
All scenarios use defaults: ENTRIES=16, CNT_W=2, idx = pc[5:2].
1. Reset then lookup 0x40 -> hit=0, taken=0, target=0x44, mispredict_cnt=0.
2. Update pc=0x40 taken, target 0x100; next cycle lookup 0x40 -> hit=1, taken=1, target=0x100, mispredict_cnt=1 (miss predicted not-taken).
3. Continue from 2:
   - Two more taken updates at 0x40 -> ctr=3, no new mispredicts.
   - Two not-taken updates -> ctr 2 then 1, mispredict_cnt=3.
   - Lookup 0x40 -> taken=0, target=0x44, hit=1.
4. Aliasing:
   - With 0x40 valid, lookup 0x80 (same idx 0, different tag) -> hit=0, target=0x84.
   - Update 0x80 taken, target 0x200 -> lookup 0x40 now misses.
   - Lookup 0x80 -> target 0x200.
5. Target change: entry at 0x40 (ctr=3, target 0x100), update taken with target 0x180 -> mispredict_cnt +1; next lookup target=0x180.
6. Clear and reset priority:
   - clear_i and update same cycle -> all lookups miss afterwards; counter unchanged.
   - Assert rst_i between clock edges -> outputs drop to miss immediately; mispredict_cnt=0.
   - Force 65535 mispredicts -> count holds at 0xFFFF.
